pingpong_bram_ctrl: RTL



---
 rtl/params_pkg.sv | 12 +
 rtl/pingpong_bram_ctrl_bram.sv | 30 +++
 rtl/pingpong_bram_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Default sizing for the ping-pong buffer controller, plus a small sizing helper
// shared by the controller and its storage.
package params_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 256;
  localparam int NUM_BUFS_DEF   = 2;
  localparam int RD_LATENCY_DEF = 1;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction
endpackage

// File: rtl/pingpong_bram_ctrl_bram.sv
// Simple dual-port block RAM with a CLK_LATENCY-deep registered read path.
// The contents are never reset.
module pingpong_bram_ctrl_bram #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_W      = 9,
  parameter int CLK_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem    [2**ADDR_W];
  logic [DATA_WIDTH-1:0] pipe_q [CLK_LATENCY];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // stage 0 is the array read; later stages only add latency
  always_ff @(posedge clk) begin
    if (re) pipe_q[0] <= mem[raddr];
    for (int i = 1; i < CLK_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rdata = pipe_q[CLK_LATENCY-1];
endmodule

// File: rtl/pingpong_bram_ctrl.sv
// N-way ping-pong buffer controller. The writer fills one buffer while the reader
// drains another. Buffers are handed over by commit and release, which rotate the indices.
module pingpong_bram_ctrl
  import params_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  DEPTH      = DEPTH_DEF,
  parameter int  NUM_BUFS   = NUM_BUFS_DEF,
  parameter int  RD_LATENCY = RD_LATENCY_DEF,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int BUF_W      = max1($clog2(NUM_BUFS)),
  localparam int CNT_W      = $clog2(NUM_BUFS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  input  logic                  rd_release,
  output logic                  rd_ready,
  output logic [BUF_W-1:0]      wr_buf_idx,
  output logic [BUF_W-1:0]      rd_buf_idx,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  ovf_err,
  output logic                  udf_err
);
  logic [BUF_W-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc, commit_acc, release_acc;

  assign wr_ready    = (occ_q < CNT_W'(NUM_BUFS));
  assign rd_ready    = (occ_q != '0);
  assign wr_acc      = wr_en && wr_ready;
  assign rd_acc      = rd_en && rd_ready;
  assign commit_acc  = wr_commit && wr_ready;
  assign release_acc = rd_release && rd_ready;

  assign rd_data_vld = vld_q[RD_LATENCY-1];
  assign rd_data     = rd_data_vld ? mem_rdata : hold_q;
  assign wr_buf_idx  = wr_idx_q;
  assign rd_buf_idx  = rd_idx_q;
  assign occupancy   = occ_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    occ_d    = occ_q;
    vld_d    = '0;
    if (commit_acc)  wr_idx_d = wr_idx_q + 1'b1;
    if (release_acc) rd_idx_d = rd_idx_q + 1'b1;
    case ({commit_acc, release_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    ovf_d = ovf_q | (wr_commit & ~wr_ready);
    udf_d = udf_q | (rd_release & ~rd_ready);
    // read-valid pipeline tracks the RAM read stages one-for-one
    vld_d[0] = rd_acc;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
    hold_d = rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
      hold_q   <= hold_d;
    end
  end

  // buffer index forms the upper address bits; reads capture their buffer at issue
  pingpong_bram_ctrl_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (BUF_W + ADDR_W),
    .CLK_LATENCY(RD_LATENCY)
  ) u_bram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr({wr_idx_q, wr_addr}),
    .wdata(wr_data),
    .re   (rd_acc),
    .raddr({rd_idx_q, rd_addr}),
    .rdata(mem_rdata)
  );
endmodule
